// File: rtl/dmem_bridge.sv
// Data-memory bridge between the CPU MEM stage and a valid/ready memory port.
// A one-entry write buffer hides store latency; load misses stall the pipeline.
module dmem_bridge #(
    parameter int unsigned REG_WIDTH       = 32,
    parameter int unsigned DMEM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset_b,

    input  logic                       cpu_read,
    input  logic                       cpu_write,
    input  logic [31:0]                cpu_addr,
    input  logic [REG_WIDTH-1:0]       cpu_wdata,
    output logic [REG_WIDTH-1:0]       cpu_rdata,
    output logic                       stall,

    output logic                       mreq_valid,
    input  logic                       mreq_ready,
    output logic                       mreq_we,
    output logic [DMEM_ADDR_WIDTH-1:0] mreq_addr,
    output logic [REG_WIDTH-1:0]       mreq_wdata,
    input  logic                       mrsp_valid,
    input  logic [REG_WIDTH-1:0]       mrsp_data,

    output logic [31:0]                stall_cycles
);

    typedef enum logic [1:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StRdDone
    } state_e;

    state_e                     state_q, state_d;
    logic                       wb_valid_q, wb_valid_d;
    logic [DMEM_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [REG_WIDTH-1:0]       wb_data_q, wb_data_d;
    logic [REG_WIDTH-1:0]       rdata_q, rdata_d;
    logic [31:0]                stall_cnt_q, stall_cnt_d;

    logic [DMEM_ADDR_WIDTH-1:0] word_addr;
    logic                       is_load;
    logic                       is_store;
    logic                       wb_hit;
    logic                       wb_drain;
    logic                       unused_addr_bits;

    assign word_addr        = cpu_addr[DMEM_ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{cpu_addr[31:DMEM_ADDR_WIDTH+2], cpu_addr[1:0]};

    // A simultaneous read and write is a load; the store half is dropped.
    assign is_load  = cpu_read;
    assign is_store = cpu_write & ~cpu_read;

    assign wb_hit   = wb_valid_q & (wb_addr_q == word_addr);
    assign wb_drain = (state_q == StIdle) & wb_valid_q & mreq_ready;

    always_comb begin
        state_d    = state_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        rdata_d    = rdata_q;

        stall      = 1'b0;
        cpu_rdata  = '0;
        mreq_valid = 1'b0;
        mreq_we    = 1'b0;
        mreq_addr  = wb_addr_q;
        mreq_wdata = wb_data_q;

        case (state_q)
            StIdle: begin
                if (wb_valid_q) begin
                    mreq_valid = 1'b1;
                    mreq_we    = 1'b1;
                    if (mreq_ready) begin
                        wb_valid_d = 1'b0;
                    end
                end

                if (is_load) begin
                    if (wb_hit) begin
                        cpu_rdata = wb_data_q;
                    end else begin
                        // Drain any buffered store before the read goes out.
                        stall = 1'b1;
                        if (!wb_valid_q) begin
                            state_d = StRdReq;
                        end
                    end
                end else if (is_store) begin
                    if (!wb_valid_q || wb_drain || wb_hit) begin
                        wb_valid_d = 1'b1;
                        wb_addr_d  = word_addr;
                        wb_data_d  = cpu_wdata;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end

            StRdReq: begin
                stall      = 1'b1;
                mreq_valid = 1'b1;
                mreq_we    = 1'b0;
                mreq_addr  = word_addr;
                mreq_wdata = '0;
                if (mreq_ready) begin
                    state_d = StRdWait;
                end
            end

            StRdWait: begin
                stall = 1'b1;
                if (mrsp_valid) begin
                    rdata_d = mrsp_data;
                    state_d = StRdDone;
                end
            end

            StRdDone: begin
                cpu_rdata = rdata_q;
                state_d   = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset_b) begin
            state_q     <= StIdle;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            rdata_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            rdata_q     <= rdata_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed scenarios plus random loads/stores, checked by a
// scoreboard against a flat reference memory and a behavioural memory model.
module tb_dmem_bridge;

    localparam int RW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_b;
    logic          cpu_read;
    logic          cpu_write;
    logic [31:0]   cpu_addr;
    logic [RW-1:0] cpu_wdata;
    logic [RW-1:0] cpu_rdata;
    logic          stall;
    logic          mreq_valid;
    logic          mreq_ready;
    logic          mreq_we;
    logic [AW-1:0] mreq_addr;
    logic [RW-1:0] mreq_wdata;
    logic          mrsp_valid;
    logic [RW-1:0] mrsp_data;
    logic [31:0]   stall_cycles;

    always #5 clk = ~clk;

    dmem_bridge #(
        .REG_WIDTH      (RW),
        .DMEM_ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .stall       (stall),
        .mreq_valid  (mreq_valid),
        .mreq_ready  (mreq_ready),
        .mreq_we     (mreq_we),
        .mreq_addr   (mreq_addr),
        .mreq_wdata  (mreq_wdata),
        .mrsp_valid  (mrsp_valid),
        .mrsp_data   (mrsp_data),
        .stall_cycles(stall_cycles)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_q   [$];
    int          ready_mode  = 0;  // 0 always ready, 1 never, 2 random, 3 low until ready_until
    int          ready_until = 0;
    int          rsp_delay   = 1;  // 0 selects a random 1..3 cycle latency
    int          cyc   = 0;
    int          n_wr  = 0;
    int          n_rd  = 0;
    int          mon_stall  = 0;
    int          stall_base = 0;

    function automatic logic [31:0] init_val(input int i);
        if (i == 16) return 32'hCAFE_0001;
        return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic to_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) to_slot();
    endtask

    // Memory model: records handshakes just before the edge, drives ready/response after it.
    initial begin : mem_model
        bit          pend;
        int          pend_cnt;
        logic [9:0]  pend_addr;
        pend = 1'b0;
        pend_cnt = 0;
        pend_addr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
        mreq_ready = 1'b1;
        mrsp_valid = 1'b0;
        mrsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset_b && mreq_valid && mreq_ready) begin
                if (mreq_we) begin
                    mem[mreq_addr] = mreq_wdata;
                    n_wr++;
                end else begin
                    n_rd++;
                    pend      = 1'b1;
                    pend_addr = mreq_addr;
                    pend_cnt  = (rsp_delay == 0) ? int'($urandom_range(3, 1)) : rsp_delay;
                end
            end
            @(posedge clk);
            #2;
            cyc++;
            mrsp_valid = 1'b0;
            mrsp_data  = '0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    pend       = 1'b0;
                    mrsp_valid = 1'b1;
                    mrsp_data  = mem[pend_addr];
                end
            end
            case (ready_mode)
                0:       mreq_ready = 1'b1;
                1:       mreq_ready = 1'b0;
                2:       mreq_ready = ($urandom_range(9, 0) < 6);
                default: mreq_ready = (cyc > ready_until);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every completed load and checks request stability.
    initial begin : monitor
        logic       pv;
        logic       pwe;
        logic [9:0] paddr;
        pv = 1'b0;
        pwe = 1'b0;
        paddr = '0;
        forever begin
            @(negedge clk);
            if (!reset_b) begin
                if (stall) mon_stall++;
                if (cpu_read && !stall) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL load completion: got %h with no load outstanding",
                                 cpu_rdata);
                    end else begin
                        check("load data", cpu_rdata, exp_q.pop_front());
                    end
                end else begin
                    check("idle rdata", cpu_rdata, 32'h0);
                end
                if (pv) begin
                    check("req held valid", 32'(mreq_valid), 32'h1);
                    check("req held we", 32'(mreq_we), 32'(pwe));
                    check("req held addr", 32'(mreq_addr), 32'(paddr));
                end
                pv    = mreq_valid && !mreq_ready;
                pwe   = mreq_we;
                paddr = mreq_addr;
            end else begin
                pv = 1'b0;
            end
        end
    end

    // Presents one CPU operation, updates the reference model, waits for stall to drop.
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, output int nst);
        int w;
        w = int'((addr >> 2) & 32'h3FF);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = data;
        if (rd) exp_q.push_back(ref_mem[w]);
        else if (wr) ref_mem[w] = data;
        nst = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            nst++;
            if (nst >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL op timeout: stall still 1 after %0d cycles, addr %h", nst, addr);
                break;
            end
        end
        to_slot();
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic do_reset();
        ready_mode = 0;
        idle(2);
        reset_b   = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        to_slot();
        reset_b = 1'b0;
        exp_q.delete();
        stall_base = mon_stall;
        @(negedge clk);
        check("reset stall", 32'(stall), 32'h0);
        check("reset mreq_valid", 32'(mreq_valid), 32'h0);
        check("reset cpu_rdata", cpu_rdata, 32'h0);
        check("reset stall_cycles", stall_cycles, 32'h0);
        to_slot();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          nst;
        int          wr0;
        int          rd0;
        int unsigned sel;
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] d;

        reset_b   = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        to_slot();
        reset_b = 1'b0;
        do_reset();

        // Store into an empty buffer, then watch it drain.
        do_op(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, nst);
        check("st10 stall", 32'(nst), 32'd0);
        @(negedge clk);
        check("st10 mreq_valid", 32'(mreq_valid), 32'h1);
        check("st10 mreq_we", 32'(mreq_we), 32'h1);
        check("st10 mreq_addr", 32'(mreq_addr), 32'd4);
        check("st10 mreq_wdata", mreq_wdata, 32'hDEAD_BEEF);
        to_slot();

        // Load forwarded from the buffer while memory refuses the write.
        ready_mode = 1;
        do_op(1'b0, 1'b1, 32'h20, 32'h11, nst);
        check("st20 stall", 32'(nst), 32'd0);
        rd0 = n_rd;
        do_op(1'b1, 1'b0, 32'h20, 32'h0, nst);
        check("ld20 fwd stall", 32'(nst), 32'd0);
        idle(2);
        check("ld20 no read req", 32'(n_rd - rd0), 32'd0);

        // Minimum load-miss penalty.
        do_reset();
        rsp_delay = 1;
        do_op(1'b1, 1'b0, 32'h40, 32'h0, nst);
        check("ld40 stall", 32'(nst), 32'd3);
        check("ld40 stall_cycles", stall_cycles, 32'd3);

        // Second store to another word waits for the first to drain.
        do_reset();
        ready_mode = 1;
        do_op(1'b0, 1'b1, 32'h08, 32'hA5A5_0008, nst);
        check("st08 stall", 32'(nst), 32'd0);
        ready_until = cyc + 4;
        ready_mode  = 3;
        do_op(1'b0, 1'b1, 32'h0C, 32'h0C0C_1234, nst);
        check("st0c stall", 32'(nst), 32'd4);
        @(negedge clk);
        check("st0c mreq_valid", 32'(mreq_valid), 32'h1);
        check("st0c mreq_addr", 32'(mreq_addr), 32'd3);
        check("st0c mreq_wdata", mreq_wdata, 32'h0C0C_1234);
        check("st08 in memory", mem[2], 32'hA5A5_0008);
        to_slot();

        // Reset while a read is outstanding; the late response must be ignored.
        do_reset();
        rsp_delay = 5;
        cpu_read  = 1'b1;
        cpu_addr  = 32'h50;
        idle(2);
        @(negedge clk);
        check("rdwait stall", 32'(stall), 32'h1);
        to_slot();
        reset_b  = 1'b1;
        cpu_read = 1'b0;
        to_slot();
        reset_b = 1'b0;
        stall_base = mon_stall;
        @(negedge clk);
        check("abort stall", 32'(stall), 32'h0);
        check("abort mreq_valid", 32'(mreq_valid), 32'h0);
        check("abort stall_cycles", stall_cycles, 32'h0);
        to_slot();
        idle(5);
        @(negedge clk);
        check("stray rsp stall", 32'(stall), 32'h0);
        check("stray rsp mreq_valid", 32'(mreq_valid), 32'h0);
        check("stray rsp stall_cycles", stall_cycles, 32'h0);
        to_slot();
        rsp_delay = 1;
        do_op(1'b1, 1'b0, 32'h50, 32'h0, nst);
        check("ld50 after abort stall", 32'(nst), 32'd3);

        // Read and write together behave as a load.
        ready_mode = 0;
        idle(2);
        wr0 = n_wr;
        rd0 = n_rd;
        do_op(1'b1, 1'b1, 32'h30, 32'hBAD0_BAD0, nst);
        check("rw30 stall", 32'(nst), 32'd3);
        idle(2);
        check("rw30 no write req", 32'(n_wr - wr0), 32'd0);
        check("rw30 one read req", 32'(n_rd - rd0), 32'd1);

        // Random traffic over a small window of words to exercise hits and conflicts.
        rsp_delay  = 0;
        ready_mode = 2;
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(99, 0);
            r   = $urandom();
            a   = (r & 32'hFFFF_F003) | (32'($urandom_range(7, 0)) << 2);
            d   = $urandom();
            if (sel < 45) do_op(1'b0, 1'b1, a, d, nst);
            else if (sel < 90) do_op(1'b1, 1'b0, a, d, nst);
            else do_op(1'b1, 1'b1, a, d, nst);
            idle(int'($urandom_range(2, 0)));
        end
        check("random stall_cycles", stall_cycles, 32'(mon_stall - stall_base));
        ready_mode = 0;
        idle(4);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);
        end
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, meaning data word width.
REQ-002 SHALL have parameter DMEM_ADDR_WIDTH, default 10, meaning word-address width toward memory.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset_b  input  1  reset; synchronous and active-high; the port keeps the codebase name but is asserted high.
REQ-005 SHALL have port cpu_read  input  1  MEM-stage load request.
REQ-006 SHALL have port cpu_write  input  1  MEM-stage store request.
REQ-007 SHALL have port cpu_addr  input  32  byte address; word index = cpu_addr[DMEM_ADDR_WIDTH+1:2]; bits [1:0] ignored.
REQ-008 SHALL have port cpu_wdata  input  REG_WIDTH  store data.
REQ-009 SHALL have port cpu_rdata  output  REG_WIDTH  load data, valid in the cycle stall is low with cpu_read high.
REQ-010 SHALL have port stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM; CPU holds all cpu_* inputs stable while high.
REQ-011 SHALL have port mreq_valid  output  1  memory request valid.
REQ-012 SHALL have port mreq_ready  input  1  memory accepts request when valid&ready.
REQ-013 SHALL have port mreq_we  output  1  1=write, 0=read.
REQ-014 SHALL have port mreq_addr  output  DMEM_ADDR_WIDTH  word address.
REQ-015 SHALL have port mreq_wdata  output  REG_WIDTH  write data.
REQ-016 SHALL have port mrsp_valid  input  1  read response valid, one cycle, at least one cycle after read acceptance.
REQ-017 SHALL have port mrsp_data  input  REG_WIDTH  read response data.
REQ-018 SHALL have port stall_cycles  output  32  count of cycles with stall high, saturating at 0xFFFFFFFF.

Function
REQ-019 SHALL contain a one-entry write buffer (wb_valid, wb_addr, wb_data) and FSM states IDLE, RD_REQ, RD_WAIT, RD_DONE.
REQ-020 SHALL, in IDLE with wb_valid, drive mreq_valid=1, mreq_we=1, mreq_addr=wb_addr, mreq_wdata=wb_data; on mreq_ready clear wb_valid next edge.
REQ-021 SHALL accept a store with stall=0 when buffer empty, buffer draining in the same cycle, or wb_addr equals store word address (overwrite in place).
REQ-022 SHALL otherwise hold stall=1 for a store until the buffer drains, then capture it.
REQ-023 SHALL serve a load whose word address equals wb_addr with wb_valid from wb_data, stall=0, no memory request.
REQ-024 SHALL, on a load miss in IDLE, assert stall=1; if wb_valid, stay IDLE draining; if buffer empty, go to RD_REQ next edge.
REQ-025 SHALL in RD_REQ drive mreq_valid=1, mreq_we=0, mreq_addr=load word address; on mreq_ready go to RD_WAIT; stall=1.
REQ-026 SHALL in RD_WAIT hold stall=1; on mrsp_valid register mrsp_data into rdata_q and go to RD_DONE.
REQ-027 SHALL in RD_DONE drive stall=0, cpu_rdata=rdata_q, and return to IDLE next edge.
REQ-028 SHALL give minimum load-miss penalty of 3 stall cycles (empty buffer, ready and response each on first opportunity).
REQ-029 SHALL treat cpu_read and cpu_write both high as a load; the store is dropped.
REQ-030 SHALL drive mreq_valid=0 in RD_WAIT and RD_DONE, and in IDLE when wb_valid=0.
REQ-031 SHALL keep mreq_* stable while mreq_valid=1 and mreq_ready=0.
REQ-032 SHALL drive cpu_rdata=0 when no load is being completed.

Reset
REQ-033 SHALL, with reset_b high at a rising edge, set FSM=IDLE, wb_valid=0, wb_addr=0, wb_data=0, rdata_q=0, stall_cycles=0.
REQ-034 SHALL after reset present stall=0, mreq_valid=0, cpu_rdata=0 combinationally.
REQ-035 SHALL abandon any in-flight read or buffered store on reset mid-operation and ignore a later stray mrsp_valid in IDLE.

Verification
REQ-036 SHALL cover: store addr 0x10 data 0xDEADBEEF, mreq_ready=1 -> stall 0; next cycle mreq_valid=1, we=1, addr 4, wdata 0xDEADBEEF.
REQ-037 SHALL cover: store 0x20=0x11, then load 0x20 while buffered, mreq_ready=0 -> cpu_rdata=0x11, stall 0, no read request.
REQ-038 SHALL cover: load 0x40 with empty buffer, ready=1, mrsp 0xCAFE0001 one cycle after accept -> stall exactly 3 cycles, then cpu_rdata=0xCAFE0001, stall_cycles=3.
REQ-039 SHALL cover: store 0x08 buffered, store 0x0C with mreq_ready=0 for 4 cycles -> stall 4 cycles, buffer holds 0x0C/data after drain.
REQ-040 SHALL cover: load miss, reset_b high during RD_WAIT -> next cycle IDLE, stall 0, stall_cycles 0; mrsp_valid then ignored.
REQ-041 SHALL cover: cpu_read and cpu_write both high at 0x30 -> load performed, no write request issued.
